// File: rtl/kyber_pkg.sv
// Shared Kyber constants, core mode codes, controller states
// and the write-back delay-line entry.
package kyber_pkg;

    localparam int N   = 256;
    localparam int Q   = 3329;
    localparam int AW  = 8;
    localparam int TWW = 7;
    localparam int CW  = 12;

    localparam logic [CW-1:0] F_INV = 12'd1441;

    localparam logic [1:0] MODE_NTT    = 2'd0;
    localparam logic [1:0] MODE_INTT   = 2'd1;
    localparam logic [1:0] MODE_MULT   = 2'd2;
    localparam logic [1:0] MODE_ADDSUB = 2'd3;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_ISSUE  = 3'd1;
    localparam logic [2:0] S_DRAIN  = 3'd2;
    localparam logic [2:0] S_SCALE  = 3'd3;
    localparam logic [2:0] S_SDRAIN = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;

    typedef struct packed {
        logic          va;
        logic          vb;
        logic [AW-1:0] a;
        logic [AW-1:0] b;
    } wb_t;

endpackage

// File: rtl/ntt_ctrl_if.sv
// Controller <-> RAM / twiddle ROM / butterfly core bundle.
interface ntt_ctrl_if
    import kyber_pkg::*;
();
    logic           start;
    logic           op;
    logic           busy;
    logic           done;
    logic           rd_en;
    logic [AW-1:0]  rd_addr_a;
    logic [AW-1:0]  rd_addr_b;
    logic [TWW-1:0] tw_addr;
    logic [CW-1:0]  tw_data;
    logic [1:0]     bf_mode;
    logic [CW-1:0]  bf_coef;
    logic           wr_en_a;
    logic           wr_en_b;
    logic [AW-1:0]  wr_addr_a;
    logic [AW-1:0]  wr_addr_b;

    modport master (
        input  start, op, tw_data,
        output busy, done, rd_en, rd_addr_a, rd_addr_b, tw_addr,
        output bf_mode, bf_coef, wr_en_a, wr_en_b, wr_addr_a, wr_addr_b
    );

    modport slave (
        output start, op, tw_data,
        input  busy, done, rd_en, rd_addr_a, rd_addr_b, tw_addr,
        input  bf_mode, bf_coef, wr_en_a, wr_en_b, wr_addr_a, wr_addr_b
    );

endinterface

// File: rtl/ntt_addr_gen.sv
// Butterfly address generator: (layer, butterfly, op) -> (j, j+len, zeta index).
module ntt_addr_gen
    import kyber_pkg::*;
(
    input  logic [2:0]     l,
    input  logic [6:0]     b,
    input  logic           op,
    output logic [AW-1:0]  j,
    output logic [AW-1:0]  jl,
    output logic [TWW-1:0] k
);

    logic [2:0] m;
    logic [3:0] m1;
    logic [7:0] len;
    logic [7:0] g;
    logic [7:0] bb;
    logic [7:0] kk;

    always_comb begin
        m   = op ? (l + 3'd1) : (3'd7 - l);
        m1  = {1'b0, m} + 4'd1;
        bb  = {1'b0, b};
        len = 8'd1 << m;
        g   = bb >> m;
        j   = (g << m1) | (bb & (len - 8'd1));
        jl  = j + len;
        // INTT walks the zeta table backwards from the top of each layer group
        if (op)
            kk = (8'd1 << (4'd8 - {1'b0, m})) - 8'd1 - g;
        else
            kk = (8'd1 << (3'd7 - m)) + g;
        k = kk[TWW-1:0];
    end

endmodule

// File: rtl/ntt_ctrl.sv
// NTT/INTT sequencer for the shared butterfly core with a
// delay-matched write-back path.
module ntt_ctrl
    import kyber_pkg::*;
#(
    parameter int            RD_LAT  = 1,
    parameter int            BF_LAT  = 5,
    parameter int            MUL_LAT = 4,
    parameter logic [CW-1:0] F_INV   = kyber_pkg::F_INV
) (
    input logic        clk,
    input logic        rst_n,
    ntt_ctrl_if.master bus
);

    localparam int PIPE   = RD_LAT + BF_LAT;
    localparam int PIPE_S = RD_LAT + MUL_LAT;
    localparam int SI     = PIPE - PIPE_S;

    logic [2:0] state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [2:0] l_q, l_d;
    logic       op_q, op_d;
    logic [1:0] mode_q, mode_d;
    wb_t        dl_q [PIPE];
    wb_t        dl_d [PIPE];

    logic           issue, scale, pipe_busy;
    logic [AW-1:0]  j, jl;
    logic [TWW-1:0] k;
    wb_t            iss, sc;

    ntt_addr_gen u_ag (
        .l  (l_q),
        .b  (cnt_q[6:0]),
        .op (op_q),
        .j  (j),
        .jl (jl),
        .k  (k)
    );

    assign issue = (state_q == S_ISSUE);
    assign scale = (state_q == S_SCALE);

    always_comb begin
        pipe_busy = 1'b0;
        for (int i = 0; i < PIPE - 1; i++)
            pipe_busy = pipe_busy | dl_q[i].va | dl_q[i].vb;
    end

    always_comb begin
        iss = '0;
        sc  = '0;
        if (issue) iss = '{va: 1'b1, vb: 1'b1, a: j, b: jl};
        if (scale) sc  = '{va: 1'b0, vb: 1'b1, a: '0, b: cnt_q};
        dl_d[0] = iss;
        for (int i = 1; i < PIPE; i++)
            dl_d[i] = dl_q[i-1];
        // scaling has a shorter core latency, so it enters the line later
        if (scale) dl_d[SI] = sc;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        l_d     = l_q;
        op_d    = op_q;
        mode_d  = mode_q;
        case (state_q)
            S_IDLE: if (bus.start) begin
                op_d    = bus.op;
                mode_d  = bus.op ? MODE_INTT : MODE_NTT;
                l_d     = '0;
                cnt_d   = '0;
                state_d = S_ISSUE;
            end
            S_ISSUE: begin
                cnt_d = cnt_q + 8'd1;
                if (cnt_q[6:0] == 7'd127) begin
                    cnt_d   = '0;
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: if (!pipe_busy) begin
                if (l_q != 3'd6) begin
                    l_d     = l_q + 3'd1;
                    state_d = S_ISSUE;
                end else if (op_q) begin
                    mode_d  = MODE_MULT;
                    cnt_d   = '0;
                    state_d = S_SCALE;
                end else begin
                    state_d = S_DONE;
                end
            end
            S_SCALE: begin
                cnt_d = cnt_q + 8'd1;
                if (cnt_q == 8'd255) state_d = S_SDRAIN;
            end
            S_SDRAIN: if (!pipe_busy) state_d = S_DONE;
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            l_q     <= '0;
            op_q    <= 1'b0;
            mode_q  <= MODE_NTT;
            for (int i = 0; i < PIPE; i++) dl_q[i] <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            l_q     <= l_d;
            op_q    <= op_d;
            mode_q  <= mode_d;
            for (int i = 0; i < PIPE; i++) dl_q[i] <= dl_d[i];
        end
    end

    assign bus.busy      = (state_q != S_IDLE);
    assign bus.done      = (state_q == S_DONE);
    assign bus.rd_en     = issue | scale;
    assign bus.rd_addr_a = issue ? j  : (scale ? cnt_q : '0);
    assign bus.rd_addr_b = issue ? jl : (scale ? cnt_q : '0);
    assign bus.tw_addr   = issue ? k : '0;
    assign bus.bf_mode   = mode_q;
    assign bus.bf_coef   = (scale || state_q == S_SDRAIN) ? F_INV : bus.tw_data;
    assign bus.wr_en_a   = dl_q[PIPE-1].va;
    assign bus.wr_en_b   = dl_q[PIPE-1].vb;
    assign bus.wr_addr_a = dl_q[PIPE-1].a;
    assign bus.wr_addr_b = dl_q[PIPE-1].b;

endmodule
